// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions for the multiply/divide unit:
// MD opcode encoding, sequencer state encoding and default latencies.
package mips_defs;

   // MD operation codes presented by the E stage
   localparam logic [2:0] MDOP_NONE  = 3'd0;
   localparam logic [2:0] MDOP_MULT  = 3'd1;
   localparam logic [2:0] MDOP_MULTU = 3'd2;
   localparam logic [2:0] MDOP_DIV   = 3'd3;
   localparam logic [2:0] MDOP_DIVU  = 3'd4;
   localparam logic [2:0] MDOP_MTHI  = 3'd5;
   localparam logic [2:0] MDOP_MTLO  = 3'd6;

   // Sequencer states
   typedef enum logic [0:0] {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // Default fixed latencies (busy cycles after the start cycle)
   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   // True for the ops that occupy the unit for several cycles
   function automatic logic is_md_arith(input logic [2:0] op);
      return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
   endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational multiply/divide result generator. Produces the full HI/LO
// result for the op currently in E; the controller only latches it.
module md_result_calc
   import mips_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       mdop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div_by_zero
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic                      b_zero;
   logic                      sdiv_ovf;
   logic [WIDTH-1:0]          sdiv_b;
   logic [WIDTH-1:0]          udiv_b;
   logic signed [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0]        prod_u;
   logic signed [WIDTH-1:0]   quot_s;
   logic signed [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]          quot_u;
   logic [WIDTH-1:0]          rem_u;

   assign b_zero   = (b == '0);
   // Most-negative / -1 overflows; dividing by 1 instead yields exactly the
   // architected result (quotient = dividend, remainder = 0).
   assign sdiv_ovf = (a == MOST_NEG) && (b == '1);
   // Keep the dividers away from a zero divisor; the result is discarded then.
   assign sdiv_b   = (b_zero || sdiv_ovf) ? WIDTH'(1) : b;
   assign udiv_b   = b_zero ? WIDTH'(1) : b;

   assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign quot_s = $signed(a) / $signed(sdiv_b);
   assign rem_s  = $signed(a) % $signed(sdiv_b);
   assign quot_u = a / udiv_b;
   assign rem_u  = a % udiv_b;

   // Select the result pair for the requested op
   always_comb begin
      res_hi      = '0;
      res_lo      = '0;
      div_by_zero = 1'b0;
      case (mdop)
         MDOP_MULT:  {res_hi, res_lo} = $unsigned(prod_s);
         MDOP_MULTU: {res_hi, res_lo} = prod_u;
         MDOP_DIV: begin
            res_lo      = $unsigned(quot_s);
            res_hi      = $unsigned(rem_s);
            div_by_zero = b_zero;
         end
         MDOP_DIVU: begin
            res_lo      = quot_u;
            res_hi      = rem_u;
            div_by_zero = b_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the E stage. Owns HI/LO, models fixed
// mult/div latency with a down counter and requests a D-stage stall while
// the unit is (or is about to become) busy.
module md_unit_ctrl
   import mips_defs::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mdop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             md_in_d,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             stall_md
);

   md_state_t        state_reg, state_next;
   logic [3:0]       cnt_reg, cnt_next;
   logic [WIDTH-1:0] hi_reg, lo_reg;
   logic [WIDTH-1:0] pend_hi_reg, pend_lo_reg;
   logic             pend_dz_reg;

   logic [WIDTH-1:0] res_hi, res_lo;
   logic             div_by_zero;
   logic             arith_req;
   logic             accept;
   logic             finish;

   md_result_calc #(.WIDTH(WIDTH)) u_calc (
      .mdop        (mdop),
      .a           (a),
      .b           (b),
      .res_hi      (res_hi),
      .res_lo      (res_lo),
      .div_by_zero (div_by_zero)
   );

   assign arith_req = start && is_md_arith(mdop);
   // Starts while busy are ignored; only an idle unit accepts work
   assign accept    = arith_req && (state_reg == MD_IDLE);
   assign finish    = (state_reg == MD_BUSY) && (cnt_reg == 4'd1);

   // State, counter, pending result and HI/LO registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg   <= MD_IDLE;
         cnt_reg     <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         pend_hi_reg <= '0;
         pend_lo_reg <= '0;
         pend_dz_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            pend_hi_reg <= res_hi;
            pend_lo_reg <= res_lo;
            pend_dz_reg <= div_by_zero;
         end
         if (finish && !pend_dz_reg) begin
            hi_reg <= pend_hi_reg;
            lo_reg <= pend_lo_reg;
         end
         if (start && (state_reg == MD_IDLE) && (mdop == MDOP_MTHI)) hi_reg <= a;
         if (start && (state_reg == MD_IDLE) && (mdop == MDOP_MTLO)) lo_reg <= a;
      end
   end

   // Next state and busy-counter sequencing
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         MD_IDLE: begin
            if (accept) begin
               state_next = MD_BUSY;
               cnt_next   = ((mdop == MDOP_MULT) || (mdop == MDOP_MULTU)) ?
                            4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            end
         end
         MD_BUSY: begin
            if (cnt_reg <= 4'd1) begin
               state_next = MD_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: begin
            state_next = MD_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs: busy from state, stall also covers the op still sitting in E
   always_comb begin
      busy     = (state_reg == MD_BUSY);
      stall_md = md_in_d && (busy || arith_req);
   end

   assign hi = hi_reg;
   assign lo = lo_reg;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed scenarios plus randomized
// ops checked against a transaction-level arithmetic model.
module tb_md_unit_ctrl;
   import mips_defs::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  mdop = 3'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        md_in_d = 1'b0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall_md;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   md_unit_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mdop     (mdop),
      .a        (a),
      .b        (b),
      .md_in_d  (md_in_d),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo),
      .stall_md (stall_md)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Architectural result of an arithmetic op, from plain 64-bit arithmetic
   function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] h, output logic [31:0] l, output bit upd);
      longint      sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      h = exp_hi;
      l = exp_lo;
      upd = 1'b1;
      if (op == MDOP_MULT) begin
         p = 64'(sx * sy);
         h = p[63:32];
         l = p[31:0];
      end else if (op == MDOP_MULTU) begin
         p = {32'd0, x} * {32'd0, y};
         h = p[63:32];
         l = p[31:0];
      end else if (y == 32'd0) begin
         upd = 1'b0;
      end else if (op == MDOP_DIV) begin
         q = sx / sy;
         r = sx % sy;
         l = 32'(q);
         h = 32'(r);
      end else begin
         p = {32'd0, x} / {32'd0, y};
         l = p[31:0];
         p = {32'd0, x} % {32'd0, y};
         h = p[31:0];
      end
   endfunction

   // Issue a mult/div; optionally throw ignored starts at the busy unit
   task automatic run_arith(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                            input logic d, input bit junk, input string name);
      int          n;
      logic [31:0] nh, nl;
      bit          upd;
      n = ((op == MDOP_MULT) || (op == MDOP_MULTU)) ? 5 : 10;
      model(op, x, y, nh, nl, upd);
      start = 1'b1; mdop = op; a = x; b = y; md_in_d = d;
      @(negedge clk);
      check_val({name, ".stall_start"}, 64'(stall_md), 64'(d));
      check_val({name, ".busy_start"}, 64'(busy), 64'd0);
      next_cycle();
      for (int i = 1; i <= n; i++) begin
         if (junk) begin
            start = 1'($urandom_range(0, 1));
            mdop  = 3'($urandom_range(0, 7));
            a     = $urandom;
            b     = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         check_val({name, ".busy"}, 64'(busy), 64'd1);
         check_val({name, ".stall_busy"}, 64'(stall_md), 64'(d));
         check_val({name, ".hi_hold"}, 64'(hi), 64'(exp_hi));
         next_cycle();
      end
      start = 1'b0; mdop = MDOP_NONE;
      if (upd) begin
         exp_hi = nh;
         exp_lo = nl;
      end
      @(negedge clk);
      check_val({name, ".busy_fall"}, 64'(busy), 64'd0);
      check_val({name, ".stall_fall"}, 64'(stall_md), 64'd0);
      check_val({name, ".hi"}, 64'(hi), 64'(exp_hi));
      check_val({name, ".lo"}, 64'(lo), 64'(exp_lo));
      $display("txn %s op=%0d a=%08h b=%08h d=%0d -> hi=%08h lo=%08h", name, op, x, y, d, hi, lo);
      md_in_d = 1'b0;
      next_cycle();
   endtask

   // mthi/mtlo and no-op codes: single-edge effect, never busy or stalling
   task automatic run_single(input logic [2:0] op, input logic [31:0] x, input logic d, input string name);
      start = 1'b1; mdop = op; a = x; b = $urandom; md_in_d = d;
      @(negedge clk);
      check_val({name, ".stall"}, 64'(stall_md), 64'd0);
      next_cycle();
      start = 1'b0; mdop = MDOP_NONE;
      if (op == MDOP_MTHI) exp_hi = x;
      if (op == MDOP_MTLO) exp_lo = x;
      @(negedge clk);
      check_val({name, ".busy"}, 64'(busy), 64'd0);
      check_val({name, ".hi"}, 64'(hi), 64'(exp_hi));
      check_val({name, ".lo"}, 64'(lo), 64'(exp_lo));
      $display("txn %s op=%0d a=%08h -> hi=%08h lo=%08h", name, op, x, hi, lo);
      md_in_d = 1'b0;
      next_cycle();
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] x, y;
      int          sel;

      // Reset state
      next_cycle();
      next_cycle();
      @(negedge clk);
      check_val("reset.busy", 64'(busy), 64'd0);
      check_val("reset.hi", 64'(hi), 64'd0);
      check_val("reset.lo", 64'(lo), 64'd0);
      check_val("reset.stall", 64'(stall_md), 64'd0);
      reset = 1'b1;
      next_cycle();

      run_arith(MDOP_MULT,  32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, "mult");
      check_val("mult.hi_val", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      check_val("mult.lo_val", 64'(lo), 64'h0000_0000_FFFF_FFFE);
      run_arith(MDOP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, "multu");
      check_val("multu.hi_val", 64'(hi), 64'h1);
      run_arith(MDOP_DIV,   32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div");
      check_val("div.lo_val", 64'(lo), 64'h0000_0000_FFFF_FFFD);
      check_val("div.hi_val", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      run_arith(MDOP_DIVU,  32'd7, 32'd2, 1'b0, 1'b0, "divu");
      check_val("divu.lo_val", 64'(lo), 64'd3);
      check_val("divu.hi_val", 64'(hi), 64'd1);

      run_single(MDOP_MTHI, 32'h1234, 1'b0, "mthi");
      run_single(MDOP_MTLO, 32'h5678, 1'b0, "mtlo");
      run_arith(MDOP_DIV, 32'd99, 32'd0, 1'b0, 1'b0, "div0");
      check_val("div0.hi_val", 64'(hi), 64'h1234);
      check_val("div0.lo_val", 64'(lo), 64'h5678);

      run_arith(MDOP_MULT, 32'd3, 32'd4, 1'b1, 1'b0, "stall_win");
      run_arith(MDOP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, "div_ovf");
      check_val("div_ovf.lo_val", 64'(lo), 64'h8000_0000);
      check_val("div_ovf.hi_val", 64'(hi), 64'h0);
      run_single(MDOP_NONE, 32'hDEAD, 1'b1, "nop0");
      run_single(3'd7, 32'hBEEF, 1'b1, "nop7");

      // Randomized ops
      for (int k = 0; k < 30; k++) begin
         op  = 3'($urandom_range(0, 7));
         x   = $urandom;
         y   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) y = 32'd0;
         if (sel == 1) y = 32'($urandom_range(1, 9));
         if (sel == 2) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
         if (is_md_arith(op))
            run_arith(op, x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
         else
            run_single(op, x, 1'($urandom_range(0, 1)), "rand");
      end

      // Reset in busy cycle 4 of a divide
      run_single(MDOP_MTHI, 32'hAAAA5555, 1'b0, "pre_rst");
      start = 1'b1; mdop = MDOP_DIV; a = 32'd100; b = 32'd7;
      next_cycle();
      start = 1'b0; mdop = MDOP_NONE;
      for (int i = 1; i <= 3; i++) next_cycle();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      check_val("rst_mid.busy", 64'(busy), 64'd0);
      check_val("rst_mid.hi", 64'(hi), 64'd0);
      check_val("rst_mid.lo", 64'(lo), 64'd0);
      $display("txn rst_mid busy=%0d hi=%08h lo=%08h", busy, hi, lo);
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         @(negedge clk);
         check_val("rst_late.busy", 64'(busy), 64'd0);
      end
      check_val("rst_late.hi", 64'(hi), 64'd0);
      check_val("rst_late.lo", 64'(lo), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
